// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: ALU select codes and sequencer state encoding
package alu_op_sequencer_pkg;
  localparam logic [2:0] SEL_ZERO = 3'b000;
  localparam logic [2:0] SEL_AND  = 3'b001;
  localparam logic [2:0] SEL_OR   = 3'b010;
  localparam logic [2:0] SEL_XOR  = 3'b011;
  localparam logic [2:0] SEL_NOT  = 3'b100;
  localparam logic [2:0] SEL_SUB  = 3'b101;
  localparam logic [2:0] SEL_ADD  = 3'b110;
  localparam logic [2:0] SEL_ONES = 3'b111;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 2**REG_AW x DATA_W regs, sync write (we/wa/wd), comb reads ra->qa, rb->qb, rc->qc
module alu_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rc,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic [DATA_W-1:0] qc
);
  logic [DATA_W-1:0] regs [2**REG_AW];
  always_ff @(posedge clock) begin
    if (reset) regs <= '{default: '0};
    else if (we) regs[wa] <= wd;
  end
  assign qa = regs[ra];
  assign qb = regs[rb];
  assign qc = regs[rc];
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready command stage driving an 8-bit ALU (alu_a/b/sel/en, bus alu_y), writing back to a regfile; done/result/flags report, rd_addr/rd_data debug read
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [2:0]        cmd_sel,
  input  logic [REG_AW-1:0] cmd_dst,
  input  logic [REG_AW-1:0] cmd_srca,
  input  logic [REG_AW-1:0] cmd_srcb,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  output logic              alu_en,
  input  logic [DATA_W-1:0] alu_y,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_n,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  state_t state, state_nx;
  logic accept, go, we;
  logic [REG_AW-1:0] dst_q, wa;
  logic [DATA_W-1:0] wd, qa, qb;
  alu_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clock(clock), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra(cmd_srca), .rb(cmd_srcb), .rc(rd_addr),
    .qa(qa), .qb(qb), .qc(rd_data)
  );
  assign cmd_ready = state == IDLE;
  assign alu_en = state == DRIVE;
  assign done = state == DONE;
  assign flag_z = result == '0;
  assign flag_n = result[DATA_W-1];
  always_comb begin
    accept = cmd_valid && cmd_ready;
    go = accept && !cmd_load;
    state_nx = state == IDLE ? (accept ? (cmd_load ? DONE : DRIVE) : IDLE) :
               state == DRIVE ? DONE : IDLE;
    // loads write at the accept edge, ALU ops at the closing edge of DRIVE
    we = (accept && cmd_load) || state == DRIVE;
    wa = state == DRIVE ? dst_q : cmd_dst;
    wd = state == DRIVE ? alu_y : cmd_imm;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // operands are captured at accept so DRIVE sees pre-write register values
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      dst_q <= '0;
      result <= '0;
    end else begin
      alu_a <= go ? qa : '0;
      alu_b <= go ? qb : '0;
      alu_sel <= go ? cmd_sel : '0;
      if (go) dst_q <= cmd_dst;
      if (we) result <= wd;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed + random self-checking bench with a behavioural register-file model
module tb_alu_op_sequencer;
  logic clock = 0, reset, cmd_valid, cmd_ready, cmd_load, alu_en, done, flag_z, flag_n;
  logic [2:0] cmd_sel, alu_sel;
  logic [1:0] cmd_dst, cmd_srca, cmd_srcb, rd_addr;
  logic [7:0] cmd_imm, alu_a, alu_b, alu_y, result, rd_data;
  logic [7:0] model [4];
  int errors = 0, checks = 0, accepts, dones;

  alu_op_sequencer dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_sel(cmd_sel), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca),
    .cmd_srcb(cmd_srcb), .cmd_imm(cmd_imm), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_en(alu_en), .alu_y(alu_y), .done(done), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] alu_fn(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'b000: return 8'h00;
      3'b001: return a & b;
      3'b010: return a | b;
      3'b011: return a ^ b;
      3'b100: return ~a;
      3'b101: return a - b;
      3'b110: return a + b;
      default: return 8'hFF;
    endcase
  endfunction

  // the external ALU: garbage on the bus when not enabled exposes mistimed sampling
  assign alu_y = alu_en ? alu_fn(alu_sel, alu_a, alu_b) : 8'hA5;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input logic [1:0] r, input logic [7:0] exp);
    rd_addr = r;
    #1 chk("rd_data", rd_data, exp);
  endtask

  task automatic do_load(input logic [1:0] dst, input logic [7:0] imm);
    chk("ld_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_load = 1; cmd_dst = dst; cmd_imm = imm;
    cmd_sel = 3'($urandom); cmd_srca = 2'($urandom); cmd_srcb = 2'($urandom);
    @(negedge clock);
    cmd_valid = 0;
    chk("ld_done", done, 1);
    chk("ld_alu_en", alu_en, 0);
    chk("ld_ready_done", cmd_ready, 0);
    chk("ld_result", result, imm);
    chk("ld_flag_z", flag_z, imm == 0);
    chk("ld_flag_n", flag_n, imm[7]);
    model[dst] = imm;
    chk_reg(dst, imm);
    @(negedge clock);
    chk("ld_done_low", done, 0);
    chk("ld_alu_en_idle", alu_en, 0);
  endtask

  task automatic do_alu(input logic [2:0] sel, input logic [1:0] dst, input logic [1:0] a, input logic [1:0] b);
    logic [7:0] ea, eb, exp;
    ea = model[a]; eb = model[b];
    exp = alu_fn(sel, ea, eb);
    chk("op_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_load = 0; cmd_sel = sel; cmd_dst = dst; cmd_srca = a; cmd_srcb = b;
    cmd_imm = 8'($urandom);
    @(negedge clock);
    cmd_valid = 0;
    chk("drv_alu_en", alu_en, 1);
    chk("drv_alu_a", alu_a, ea);
    chk("drv_alu_b", alu_b, eb);
    chk("drv_alu_sel", alu_sel, sel);
    chk("drv_done", done, 0);
    chk("drv_ready", cmd_ready, 0);
    @(negedge clock);
    chk("op_done", done, 1);
    chk("op_alu_en", alu_en, 0);
    chk("op_alu_a_zero", alu_a, 0);
    chk("op_result", result, exp);
    chk("op_flag_z", flag_z, exp == 0);
    chk("op_flag_n", flag_n, exp[7]);
    model[dst] = exp;
    chk_reg(dst, exp);
    @(negedge clock);
    chk("op_done_low", done, 0);
    chk("op_ready_idle", cmd_ready, 1);
  endtask

  initial begin
    reset = 1; cmd_valid = 0; cmd_load = 0; cmd_sel = 0; cmd_dst = 0;
    cmd_srca = 0; cmd_srcb = 0; cmd_imm = 0; rd_addr = 0;
    foreach (model[i]) model[i] = 0;
    repeat (2) @(negedge clock);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flag_z", flag_z, 1);
    chk("rst_flag_n", flag_n, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    for (int r = 0; r < 4; r++) chk_reg(2'(r), 8'h00);
    reset = 0;
    @(negedge clock);
    do_load(2'd0, 8'h3C);
    do_load(2'd1, 8'h0F);
    chk_reg(2'd0, 8'h3C);
    chk_reg(2'd1, 8'h0F);
    do_alu(3'b110, 2'd2, 2'd0, 2'd1);
    chk("add_result", result, 8'h4B);
    do_alu(3'b101, 2'd1, 2'd1, 2'd0);
    chk("sub_result", result, 8'hD3);
    chk_reg(2'd1, 8'hD3);
    do_alu(3'b000, 2'd3, 2'd0, 2'd1);
    chk("zero_flag_z", flag_z, 1);
    do_alu(3'b111, 2'd3, 2'd2, 2'd1);
    chk("ones_result", result, 8'hFF);
    // held valid: three accepts exactly three cycles apart
    accepts = 0; dones = 0;
    cmd_valid = 1; cmd_load = 0; cmd_sel = 3'b110; cmd_dst = 2'd2; cmd_srca = 2'd0; cmd_srcb = 2'd1;
    for (int c = 0; c < 9; c++) begin
      chk("held_ready", cmd_ready, c % 3 == 0);
      chk("held_done", done, c % 3 == 2);
      if (cmd_ready && cmd_valid) accepts++;
      if (done) dones++;
      @(negedge clock);
    end
    cmd_valid = 0;
    chk("held_accepts", accepts, 3);
    chk("held_dones", dones, 3);
    model[2] = model[0] + model[1];
    chk_reg(2'd2, model[2]);
    @(negedge clock);
    // reset while an XOR is in DRIVE
    cmd_valid = 1; cmd_load = 0; cmd_sel = 3'b011; cmd_dst = 2'd2; cmd_srca = 2'd0; cmd_srcb = 2'd3;
    @(negedge clock);
    cmd_valid = 0;
    chk("mid_drive_en", alu_en, 1);
    reset = 1;
    @(negedge clock);
    reset = 0;
    foreach (model[i]) model[i] = 0;
    chk("mid_done", done, 0);
    chk("mid_alu_en", alu_en, 0);
    chk("mid_result", result, 0);
    chk("mid_flag_z", flag_z, 1);
    chk("mid_ready", cmd_ready, 1);
    chk_reg(2'd2, 8'h00);
    @(negedge clock);
    chk("mid_done_after", done, 0);
    chk("mid_alu_en_after", alu_en, 0);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) do_load(2'($urandom), 8'($urandom));
      else do_alu(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 2)) begin
        chk("gap_done", done, 0);
        @(negedge clock);
      end
    end
    for (int r = 0; r < 4; r++) chk_reg(2'(r), model[r]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
